// File: rtl/ysyx_22040632_exu_mc.sv
// Multi-cycle execute unit: ALU, jumps, branches and an optional shift-add multiplier.
// Multiplier (ops 20-22) compiled in only when YSYX_22040632_EXU_MUL_EN is defined.
module ysyx_22040632_exu_mc #(
  parameter int XLEN = 64,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_wen,
  output logic [XLEN-1:0] out_pc_target,
  output logic            out_pc_chg,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(2);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(3);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(7);
  localparam logic [OPW-1:0] OP_OR    = OPW'(8);
  localparam logic [OPW-1:0] OP_AND   = OPW'(9);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(10);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(11);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(12);
  localparam logic [OPW-1:0] OP_JALR  = OPW'(13);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(14);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(15);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(16);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(17);
  localparam logic [OPW-1:0] OP_BLTU  = OPW'(18);
  localparam logic [OPW-1:0] OP_BGEU  = OPW'(19);

`ifdef YSYX_22040632_EXU_MUL_EN
  localparam logic [OPW-1:0] OP_MUL   = OPW'(20);
  localparam logic [OPW-1:0] OP_MULH  = OPW'(21);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(22);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;
`else
  typedef enum logic {S_IDLE} state_e;
`endif

  state_e state_q, state_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            chg_q, chg_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic            is_mul;
  logic            mul_done;

  logic [XLEN-1:0] a_res;
  logic            a_wen;
  logic [XLEN-1:0] a_tgt;
  logic            a_chg;
  logic            a_ill;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] link;
  logic            lt_s;
  logic            lt_u;

  assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign out_valid     = valid_q;
  assign out_result    = res_q;
  assign out_wen       = wen_q;
  assign out_pc_target = tgt_q;
  assign out_pc_chg    = chg_q;
  assign out_illegal   = ill_q;

  assign shamt  = src2[SHW-1:0];
  assign pc_imm = pc + imm;
  assign link   = pc + XLEN'(4);
  assign lt_s   = $signed(src1) < $signed(src2);
  assign lt_u   = src1 < src2;

  always_comb begin
    a_res = '0;
    a_wen = 1'b1;
    a_tgt = '0;
    a_chg = 1'b0;
    a_ill = 1'b0;
    unique case (op)
      OP_ADD:   a_res = src1 + src2;
      OP_SUB:   a_res = src1 - src2;
      OP_SLL:   a_res = src1 << shamt;
      OP_SLT:   a_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  a_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:   a_res = src1 ^ src2;
      OP_SRL:   a_res = src1 >> shamt;
      OP_SRA:   a_res = $signed(src1) >>> shamt;
      OP_OR:    a_res = src1 | src2;
      OP_AND:   a_res = src1 & src2;
      OP_AUIPC: a_res = pc_imm;
      OP_LUI:   a_res = imm;
      OP_JAL: begin
        a_res = link;
        a_tgt = pc_imm;
        a_chg = 1'b1;
      end
      OP_JALR: begin
        a_res = link;
        a_tgt = (src1 + imm) & ~XLEN'(1);
        a_chg = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        a_wen = 1'b0;
        a_tgt = pc_imm;
        unique case (op)
          OP_BEQ:  a_chg = src1 == src2;
          OP_BNE:  a_chg = src1 != src2;
          OP_BLT:  a_chg = lt_s;
          OP_BGE:  a_chg = !lt_s;
          OP_BLTU: a_chg = lt_u;
          default: a_chg = !lt_u;
        endcase
      end
      default: begin
        a_wen = 1'b0;
        a_ill = 1'b1;
      end
    endcase
  end

`ifdef YSYX_22040632_EXU_MUL_EN
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic              hsel_q, hsel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN:0]     sum_w;
  logic [2*XLEN-1:0] step_w;
  logic [2*XLEN-1:0] sprod;
  logic [XLEN-1:0]   mul_res;
  logic              sgn;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;

  assign is_mul   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
  assign mul_done = (state_q == S_MUL) && (cnt_q == LAST);
  assign sgn      = op != OP_MULHU;
  assign mag1     = (sgn && src1[XLEN-1]) ? -src1 : src1;
  assign mag2     = (sgn && src2[XLEN-1]) ? -src2 : src2;

  // {hi,lo} shifts right each step; lo starts as the multiplier magnitude
  assign sum_w   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
  assign step_w  = {sum_w, lo_q[XLEN-1:1]};
  assign sprod   = neg_q ? -step_w : step_w;
  assign mul_res = hsel_q ? sprod[2*XLEN-1:XLEN] : sprod[XLEN-1:0];
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    wen_d   = wen_q;
    tgt_d   = tgt_q;
    chg_d   = chg_q;
    ill_d   = ill_q;
`ifdef YSYX_22040632_EXU_MUL_EN
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hsel_d  = hsel_q;
    cnt_d   = cnt_q;
    if (state_q == S_MUL) begin
      {hi_d, lo_d} = step_w;
      cnt_d = cnt_q + CW'(1);
    end
    if (accept && is_mul) begin
      state_d = S_MUL;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = mag2;
      mcand_d = mag1;
      neg_d   = sgn && (src1[XLEN-1] ^ src2[XLEN-1]);
      hsel_d  = op != OP_MUL;
    end
    if (mul_done) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
`endif
    if (out_ready) valid_d = 1'b0;
    if (mul_done) begin
`ifdef YSYX_22040632_EXU_MUL_EN
      valid_d = 1'b1;
      res_d   = mul_res;
      wen_d   = 1'b1;
      tgt_d   = '0;
      chg_d   = 1'b0;
      ill_d   = 1'b0;
`endif
    end else if (accept && !is_mul) begin
      valid_d = 1'b1;
      res_d   = a_res;
      wen_d   = a_wen;
      tgt_d   = a_tgt;
      chg_d   = a_chg;
      ill_d   = a_ill;
    end
    // flush outranks completion, accept and consumption
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
`ifdef YSYX_22040632_EXU_MUL_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      wen_q   <= 1'b0;
      tgt_q   <= '0;
      chg_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      wen_q   <= wen_d;
      tgt_q   <= tgt_d;
      chg_q   <= chg_d;
      ill_q   <= ill_d;
    end
  end

`ifdef YSYX_22040632_EXU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hsel_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hsel_q  <= hsel_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040632_exu_mc.sv
// Scoreboard bench for ysyx_22040632_exu_mc (XLEN=64).
// Multiply cases follow YSYX_22040632_EXU_MUL_EN.
module tb_ysyx_22040632_exu_mc;

  typedef struct packed {
    logic [63:0] res;
    logic        wen;
    logic [63:0] tgt;
    logic        chg;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [63:0] imm = '0;
  logic [63:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        out_wen;
  logic [63:0] out_pc_target;
  logic        out_pc_chg;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sbq[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PC0  = 64'h8000_0000;

  ysyx_22040632_exu_mc #(.XLEN(64), .OPW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wen(out_wen),
    .out_pc_target(out_pc_target), .out_pc_chg(out_pc_chg),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [63:0] r, logic w,
                              logic [63:0] t, logic c, logic i);
    exp_t e;
    e.res = r; e.wen = w; e.tgt = t; e.chg = c; e.ill = i;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // monitor: one scoreboard entry per consumed output
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      exp_t a;
      a = mk(out_result, out_wen, out_pc_target, out_pc_chg, out_illegal);
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got %h want none", a);
      end else begin
        e = sbq.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL out_fields: got res=%h wen=%b tgt=%h chg=%b ill=%b want res=%h wen=%b tgt=%h chg=%b ill=%b",
                   a.res, a.wen, a.tgt, a.chg, a.ill,
                   e.res, e.wen, e.tgt, e.chg, e.ill);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] i,
                       input logic [63:0] p, input exp_t e,
                       input bit push, output int waited);
    waited = 0;
    @(negedge clk);
    op = o; src1 = a; src2 = b; imm = i; pc = p;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got waited=%0d want accept", waited);
      in_valid = 1'b0;
    end else begin
      if (push) sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic alu(input logic [4:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] r);
    int w;
    issue(o, a, b, 64'd0, PC0, mk(r, 1'b1, 64'd0, 1'b0, 1'b0), 1'b1, w);
  endtask

  task automatic ctl(input logic [4:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] i,
                     input exp_t e);
    int w;
    issue(o, a, b, i, PC0, e, 1'b1, w);
  endtask

  initial begin
    int w;
    int bad;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_target", out_pc_target, 64'd0);
    chk("rst_flags", {61'd0, out_wen, out_pc_chg, out_illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

`ifdef YSYX_22040632_EXU_MUL_EN
    // reset in the middle of a multiply
    issue(5'd20, 64'd3, 64'd5, 64'd0, PC0, mk('0, 0, '0, 0, 0), 1'b0, w);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", out_result, 64'd0);
    chk("midrst_idle", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
`endif

    issue(5'd0, 64'd5, 64'd7, 64'd0, PC0,
          mk(64'd12, 1'b1, 64'd0, 1'b0, 1'b0), 1'b1, w);
    chk("add_latency", 64'(out_valid), 64'd1);
    chk("add_wait", 64'(w), 64'd0);

    alu(5'd1, 64'd0, 64'd1, ONES);
    alu(5'd7, 64'h8000_0000_0000_0000, 64'd63, ONES);
    alu(5'd3, ONES, 64'd1, 64'd1);
    alu(5'd4, ONES, 64'd1, 64'd0);
    alu(5'd2, 64'd1, 64'd65, 64'd2);
    alu(5'd6, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    alu(5'd5, 64'hF0, 64'hFF, 64'h0F);
    alu(5'd8, 64'hF0, 64'h0F, 64'hFF);
    alu(5'd9, 64'hF0, 64'h3C, 64'h30);

    ctl(5'd10, 64'd0, 64'd0, 64'h1000, mk(64'h8000_1000, 1, 64'd0, 0, 0));
    ctl(5'd11, 64'd0, 64'd0, 64'h1234_5000, mk(64'h1234_5000, 1, 64'd0, 0, 0));
    ctl(5'd12, 64'd0, 64'd0, 64'h10,
        mk(64'h8000_0004, 1, 64'h8000_0010, 1, 0));
    ctl(5'd13, 64'h8000_0101, 64'd0, 64'd0,
        mk(64'h8000_0004, 1, 64'h8000_0100, 1, 0));
    ctl(5'd15, 64'd7, 64'd7, 64'h20, mk(64'd0, 0, 64'h8000_0020, 0, 0));
    ctl(5'd14, 64'd7, 64'd7, 64'h20, mk(64'd0, 0, 64'h8000_0020, 1, 0));
    ctl(5'd16, ONES, 64'd1, ONES - 64'd7, mk(64'd0, 0, 64'h7FFF_FFF8, 1, 0));
    ctl(5'd17, ONES, 64'd1, 64'h8, mk(64'd0, 0, 64'h8000_0008, 0, 0));
    ctl(5'd18, ONES, 64'd1, 64'h8, mk(64'd0, 0, 64'h8000_0008, 0, 0));
    ctl(5'd19, ONES, 64'd1, 64'h8, mk(64'd0, 0, 64'h8000_0008, 1, 0));
    ctl(5'd23, 64'd5, 64'd6, 64'h8, mk(64'd0, 0, 64'd0, 0, 1));

`ifdef YSYX_22040632_EXU_MUL_EN
    // MULH -3*5: latency and in_ready low throughout
    issue(5'd21, ONES - 64'd2, 64'd5, 64'd0, PC0,
          mk(ONES, 1, 64'd0, 0, 0), 1'b1, w);
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (k < 64 && (out_valid || in_ready)) bad++;
      if (k == 64) chk("mul_latency", 64'(out_valid), 64'd1);
    end
    chk("mul_busy_cycles", 64'(bad), 64'd0);
    ctl(5'd20, ONES - 64'd2, 64'd5, 64'd0, mk(ONES - 64'd14, 1, 64'd0, 0, 0));
    ctl(5'd22, ONES, 64'd2, 64'd0, mk(64'd1, 1, 64'd0, 0, 0));
    ctl(5'd21, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
        mk(64'h4000_0000_0000_0000, 1, 64'd0, 0, 0));

    // flush during cycle 30 of a multiply
    issue(5'd20, 64'd9, 64'd9, 64'd0, PC0, mk('0, 0, '0, 0, 0), 1'b0, w);
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_idle", 64'(in_ready), 64'd1);
    issue(5'd0, 64'd2, 64'd3, 64'd0, PC0,
          mk(64'd5, 1, 64'd0, 0, 0), 1'b1, w);
    chk("flush_next_accept", 64'(w), 64'd0);
    @(negedge clk);
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("flush_no_result", 64'(bad), 64'd0);
`else
    issue(5'd20, 64'd3, 64'd5, 64'd0, PC0,
          mk(64'd0, 0, 64'd0, 0, 1), 1'b1, w);
    chk("mul_undef_latency", 64'(out_valid), 64'd1);
    chk("mul_undef_ill", 64'(out_illegal), 64'd1);
`endif

    // back-pressure: output held and input stalled
    issue(5'd0, 64'd1, 64'd2, 64'd0, PC0,
          mk(64'd3, 1, 64'd0, 0, 0), 1'b1, w);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 5'd5;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_result !== 64'd3 || !out_wen) bad++;
    end
    in_valid = 1'b0;
    chk("backpressure_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;

    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
